// File: rtl/req_ack_responder.sv
// req_ack_responder: responder side of the single-key req/ack handshake.
// A request seen in IDLE captures the key, waits ACK_DELAY cycles, then
// returns a one-cycle registered ack. Every output comes straight from a
// flop, so this block never closes a combinational loop with its requester.
// Optional key-sequence checker: define RESP_KEY_CHECK_EN to build it;
// without it, err and err_count are tied to zero.
module req_ack_responder #(
   parameter int KEY_W     = 4,
   parameter int ACK_DELAY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic [KEY_W-1:0] req_key,
   output logic             ack,
   output logic             busy,
   output logic [KEY_W-1:0] last_key,
   output logic [15:0]      ack_count,
   output logic             err,
   output logic [7:0]       err_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;

   localparam logic [3:0] DELAY_INIT = 4'(ACK_DELAY);
   localparam bit         NO_WAIT    = (ACK_DELAY == 0);

   logic [1:0]       r_state;
   logic [1:0]       w_next_state;
   logic [3:0]       r_cnt;
   logic             w_capture;
   logic             r_ack;
   logic             r_busy;
   logic [KEY_W-1:0] r_last_key;
   logic [15:0]      r_ack_count;

   assign w_capture = (r_state == S_IDLE) && req;

   // Next-state decode for the IDLE -> WAIT -> ACK -> IDLE sequence.
   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (req) w_next_state = NO_WAIT ? S_ACK : S_WAIT;
         S_WAIT:  if (r_cnt == 4'd1) w_next_state = S_ACK;
         S_ACK:   w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Handshake state, delay counter and registered outputs.
   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_ack       <= 1'b0;
         r_busy      <= 1'b0;
         r_last_key  <= '0;
         r_ack_count <= 16'd0;
      end else begin
         r_state <= w_next_state;
         // ack and busy are registered copies of the state we are entering.
         r_ack   <= (w_next_state == S_ACK);
         r_busy  <= (w_next_state != S_IDLE);
         if (w_capture) begin
            r_last_key <= req_key;
            r_cnt      <= DELAY_INIT;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (r_state == S_ACK) r_ack_count <= r_ack_count + 16'd1;
      end
   end

   assign ack       = r_ack;
   assign busy      = r_busy;
   assign last_key  = r_last_key;
   assign ack_count = r_ack_count;

`ifdef RESP_KEY_CHECK_EN
   logic [KEY_W-1:0] r_expected_key;
   logic [KEY_W-1:0] w_check_key;
   logic             w_mismatch;
   logic             r_err;
   logic [7:0]       r_err_count;

   // With ACK_DELAY=0 the key is compared in the same cycle it is captured,
   // so take it from the input rather than the not-yet-updated last_key.
   assign w_check_key = (r_state == S_IDLE) ? req_key : r_last_key;
   assign w_mismatch  = (w_next_state == S_ACK) && (w_check_key != r_expected_key);

   // Sequence checker: err is raised alongside ack; counters settle after the ACK cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_expected_key <= '0;
         r_err          <= 1'b0;
         r_err_count    <= 8'd0;
      end else begin
         r_err <= w_mismatch;
         if (r_state == S_ACK) begin
            // On a match last_key equals expected_key, so last_key+1 covers
            // both the normal advance and the resynchronisation after a miss.
            r_expected_key <= r_last_key + KEY_W'(1);
            if (r_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
         end
      end
   end

   assign err       = r_err;
   assign err_count = r_err_count;
`else
   assign err       = 1'b0;
   assign err_count = 8'd0;
`endif

endmodule
